// File: rtl/tinychip_pkg.sv
// -----------------------------------------------------------------------------
// tinychip_pkg
// Shared definitions for the tinychip front end:
//   ADDR_W_DEF / INSTR_W_DEF : default instruction-memory geometry (256 x 9)
//   HALT_INSTR_DEF           : instruction word that stops fetch
//   fetch_state_t            : fetch sequencer state encoding (2 bits)
// -----------------------------------------------------------------------------
package tinychip_pkg;

   localparam int              ADDR_W_DEF     = 8;
   localparam int              INSTR_W_DEF    = 9;
   localparam logic [8:0]      HALT_INSTR_DEF = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Program-counter sequencer for the synchronous instruction memory. Drives
// every memory address, presents fetched words to decode with a valid/stall
// handshake, and handles start, zero-bubble redirects, HALT and end-of-memory
// faults.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   start, start_pc  begin fetching at start_pc (IDLE/HALTED only)
//   imem_addr        combinational address to instruction memory
//   imem_instr       registered memory data (1-cycle latency)
//   instr_out        instruction to decode (pass-through of imem_instr)
//   instr_pc         address of instr_out
//   instr_valid      instr_out holds a valid fetched instruction
//   stall            decode not ready; hold current instruction
//   redirect_valid   next fetch comes from redirect_pc
//   redirect_pc      redirect target
//   halted           sequencer is in HALTED
//   fault            sticky end-of-memory fault (WRAP_EN = 0 only)
//   retired          saturating count of consumed instructions
// -----------------------------------------------------------------------------
module fetch_sequencer
   import tinychip_pkg::*;
#(
   parameter int                 ADDR_W     = ADDR_W_DEF,
   parameter int                 INSTR_W    = INSTR_W_DEF,
   parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF,
   parameter int                 WRAP_EN    = 1,
   parameter int                 CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  start_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               halted,
   output logic               fault,
   output logic [CNT_W-1:0]   retired
);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_RUN    = RUN;
   localparam logic [1:0] S_HALTED = HALTED;

   logic [1:0]         r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_instr_pc;
   logic               r_valid;
   logic               r_halted;
   logic               r_fault;
   logic [CNT_W-1:0]   r_retired;

   logic [1:0]         w_state_nxt;
   logic [ADDR_W-1:0]  w_addr;
   logic [ADDR_W-1:0]  w_pc_nxt;
   logic [ADDR_W-1:0]  w_instr_pc_nxt;
   logic               w_valid_nxt;
   logic               w_fault_nxt;
   logic               w_consume;
   logic               w_is_halt;
   logic               w_at_max;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // A redirect consumes the presented word even while decode stalls.
   assign w_consume = r_valid & (~stall | redirect_valid);
   assign w_is_halt = (imem_instr == HALT_INSTR);
   assign w_at_max  = (r_instr_pc == {ADDR_W{1'b1}});

   always_comb begin
      w_state_nxt    = r_state;
      w_addr         = r_pc;
      w_pc_nxt       = r_pc;
      w_instr_pc_nxt = r_instr_pc;
      w_valid_nxt    = r_valid;
      w_fault_nxt    = r_fault;
      if (r_state == S_RUN) begin
         if (redirect_valid) begin
            w_addr         = redirect_pc;
            w_instr_pc_nxt = redirect_pc;
            w_pc_nxt       = redirect_pc + 1'b1;
            w_valid_nxt    = 1'b1;
         end else if (stall && r_valid) begin
            // Re-read the presented word so the memory output holds steady.
            w_addr = r_instr_pc;
         end else if (w_consume && w_is_halt) begin
            w_state_nxt = S_HALTED;
            w_valid_nxt = 1'b0;
         end else if (w_consume && w_at_max && (WRAP_EN == 0)) begin
            // The wrapped read of address 0 in flight is simply dropped.
            w_state_nxt = S_HALTED;
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b1;
         end else begin
            w_instr_pc_nxt = r_pc;
            w_pc_nxt       = r_pc + 1'b1;
            w_valid_nxt    = 1'b1;
         end
      end else begin
         w_valid_nxt = 1'b0;
         if (start) begin
            w_addr         = start_pc;
            w_instr_pc_nxt = start_pc;
            w_pc_nxt       = start_pc + 1'b1;
            w_valid_nxt    = 1'b1;
            w_fault_nxt    = 1'b0;
            w_state_nxt    = S_RUN;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_halted   <= 1'b0;
         r_fault    <= 1'b0;
         r_retired  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr_pc <= w_instr_pc_nxt;
         r_valid    <= w_valid_nxt;
         r_halted   <= (w_state_nxt == S_HALTED);
         r_fault    <= w_fault_nxt;
         if (w_consume) begin
            r_retired <= sat_inc(r_retired);
         end
      end
   end

   // Memory shares the reset, so force address 0 while it is held.
   assign imem_addr   = reset ? '0 : w_addr;
   assign instr_out   = imem_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_valid;
   assign halted      = r_halted;
   assign fault       = r_fault;
   assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] start_pc;
   logic       stall;
   logic       redirect_valid;
   logic [7:0] redirect_pc;

   logic [7:0]  addr0, addr1, pc0, pc1;
   logic [8:0]  q0, q1, out0, out1;
   logic        v0, v1, h0, h1, f0, f1;
   logic [15:0] ret0;
   logic [2:0]  ret1;

   logic [8:0] mem [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instance 0: no wrap, full counter. Instance 1: wrap, 3-bit counter.
   fetch_sequencer #(.ADDR_W(8), .INSTR_W(9), .HALT_INSTR(9'h1FF), .WRAP_EN(0), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
      .imem_addr(addr0), .imem_instr(q0), .instr_out(out0), .instr_pc(pc0),
      .instr_valid(v0), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halted(h0), .fault(f0), .retired(ret0));

   fetch_sequencer #(.ADDR_W(8), .INSTR_W(9), .HALT_INSTR(9'h1FF), .WRAP_EN(1), .CNT_W(3)) dut1 (
      .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
      .imem_addr(addr1), .imem_instr(q1), .instr_out(out1), .instr_pc(pc1),
      .instr_valid(v1), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halted(h1), .fault(f1), .retired(ret1));

   // Synchronous instruction memory with output cleared by the shared reset.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q0 <= '0;
         q1 <= '0;
      end else begin
         q0 <= mem[addr0];
         q1 <= mem[addr1];
      end
   end

   typedef struct {
      logic        start;
      logic [7:0]  sp;
      logic        stall;
      logic        redir;
      logic [7:0]  rp;
      logic [7:0]  exp_addr;
      logic        exp_valid;
      logic [7:0]  exp_pc;
      logic [8:0]  exp_instr;
      logic        exp_halted;
      logic [15:0] exp_ret;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic st, input logic [7:0] sp, input logic sl,
                               input logic rd, input logic [7:0] rp, input logic [7:0] ea,
                               input logic ev, input logic [7:0] ep, input logic [8:0] ei,
                               input logic eh, input logic [15:0] er);
      vec_t v;
      v.start = st; v.sp = sp; v.stall = sl; v.redir = rd; v.rp = rp;
      v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei;
      v.exp_halted = eh; v.exp_ret = er;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [7:0] sp, input logic sl,
                        input logic rd, input logic [7:0] rp);
      start = st; start_pc = sp; stall = sl; redirect_valid = rd; redirect_pc = rp;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 9'(i);
      mem[0] = 9'h18F; mem[1] = 9'h19D; mem[2] = 9'h1A8; mem[3] = 9'h1FF;

      tbl[0]  = mk(1, 0, 0, 0, 0,  0,  1, 0,  9'h18F, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0,  1,  1, 1,  9'h19D, 0, 1);
      tbl[2]  = mk(0, 0, 0, 0, 0,  2,  1, 2,  9'h1A8, 0, 2);
      tbl[3]  = mk(0, 0, 0, 0, 0,  3,  1, 3,  9'h1FF, 0, 3);
      tbl[4]  = mk(0, 0, 0, 0, 0,  4,  0, 0,  9'h000, 1, 4);
      tbl[5]  = mk(0, 0, 0, 0, 0,  4,  0, 0,  9'h000, 1, 4);
      tbl[6]  = mk(1, 0, 0, 0, 0,  0,  1, 0,  9'h18F, 0, 4);
      tbl[7]  = mk(0, 0, 0, 0, 0,  1,  1, 1,  9'h19D, 0, 5);
      tbl[8]  = mk(0, 0, 1, 0, 0,  1,  1, 1,  9'h19D, 0, 5);
      tbl[9]  = mk(0, 0, 1, 0, 0,  1,  1, 1,  9'h19D, 0, 5);
      tbl[10] = mk(0, 0, 1, 0, 0,  1,  1, 1,  9'h19D, 0, 5);
      tbl[11] = mk(0, 0, 0, 0, 0,  2,  1, 2,  9'h1A8, 0, 6);
      tbl[12] = mk(0, 0, 0, 1, 8,  8,  1, 8,  9'h008, 0, 7);
      tbl[13] = mk(0, 0, 0, 0, 0,  9,  1, 9,  9'h009, 0, 8);
      tbl[14] = mk(0, 0, 1, 1, 20, 20, 1, 20, 9'h014, 0, 9);
      tbl[15] = mk(0, 0, 0, 0, 0,  21, 1, 21, 9'h015, 0, 10);
      tbl[16] = mk(0, 0, 0, 1, 4,  4,  1, 4,  9'h004, 0, 11);
      tbl[17] = mk(0, 0, 0, 0, 0,  5,  1, 5,  9'h005, 0, 12);

      // Reset state; start held high must not leak onto the address.
      reset = 1'b1;
      drive(1, 8'd5, 0, 0, 0);
      tick();
      check("rst_valid", v0, 0);
      check("rst_pc", pc0, 0);
      check("rst_halted", h0, 0);
      check("rst_fault", f0, 0);
      check("rst_retired", ret0, 0);
      check("rst_addr", addr0, 0);
      drive(0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();
      check("idle_valid", v0, 0);

      for (int k = 0; k < 18; k++) begin
         drive(tbl[k].start, tbl[k].sp, tbl[k].stall, tbl[k].redir, tbl[k].rp);
         #1;
         check($sformatf("v%0d_addr", k), addr0, tbl[k].exp_addr);
         tick();
         check($sformatf("v%0d_valid", k), v0, tbl[k].exp_valid);
         check($sformatf("v%0d_halted", k), h0, tbl[k].exp_halted);
         check($sformatf("v%0d_fault", k), f0, 0);
         check($sformatf("v%0d_retired", k), ret0, tbl[k].exp_ret);
         check($sformatf("v%0d_sat_retired", k), ret1,
               (tbl[k].exp_ret > 16'd7) ? 7 : int'(tbl[k].exp_ret));
         if (tbl[k].exp_valid) begin
            check($sformatf("v%0d_pc", k), pc0, tbl[k].exp_pc);
            check($sformatf("v%0d_instr", k), out0, tbl[k].exp_instr);
         end
      end

      // Asynchronous reset while presenting pc 5.
      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", v0, 0);
      check("mid_rst_retired", ret0, 0);
      check("mid_rst_addr", addr0, 0);
      check("mid_rst_instr", out0, 0);
      check("mid_rst_halted", h0, 0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_valid", v0, 0);
      drive(1, 8'd5, 0, 0, 0);
      tick();
      check("resume_valid", v0, 1);
      check("resume_pc", pc0, 5);
      check("resume_instr", out0, 9'h005);
      // start while running is ignored.
      drive(1, 8'd100, 0, 0, 0);
      tick();
      check("run_start_ign_pc", pc0, 6);
      check("run_start_ign_ret", ret0, 1);

      // Park both instances in HALTED via the HALT word at address 3.
      drive(0, 0, 0, 1, 8'd3);
      tick();
      check("to_halt_instr", out0, 9'h1FF);
      drive(0, 0, 0, 0, 0);
      tick();
      check("parked0", h0, 1);
      check("parked1", h1, 1);

      // End-of-memory: fault without wrap, silent wrap with it.
      drive(1, 8'd254, 0, 0, 0);
      tick();
      check("end_pc254_0", pc0, 254);
      check("end_pc254_1", pc1, 254);
      drive(0, 0, 0, 0, 0);
      tick();
      check("end_pc255_0", pc0, 255);
      check("end_pc255_1", pc1, 255);
      check("end_instr255", out0, 9'h0FF);
      tick();
      check("nowrap_fault", f0, 1);
      check("nowrap_halted", h0, 1);
      check("nowrap_valid", v0, 0);
      check("wrap_pc0", pc1, 0);
      check("wrap_valid", v1, 1);
      check("wrap_fault", f1, 0);
      tick();
      check("nowrap_fault_sticky", f0, 1);
      check("wrap_pc1", pc1, 1);
      drive(1, 8'd0, 0, 0, 0);
      tick();
      check("restart_fault_clr", f0, 0);
      check("restart_halted", h0, 0);
      check("restart_pc", pc0, 0);
      check("restart_valid", v0, 1);
      check("wrap_start_ign", pc1, 2);
      check("wrap_fault_hold", f1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter sequencer that drives the address of the 256x9 synchronous instruction memory and presents fetched instructions to decode with a valid/stall handshake.
- Handles start from a given PC, sequential fetch, zero-bubble redirects (branch/jump), decode stalls, HALT detection and end-of-memory faults.
- Sits between instruction memory and the decode stage. Owns every instruction-memory address.

Parameters:
ADDR_W, 8, instruction memory address width (depth 2**ADDR_W)
INSTR_W, 9, instruction width
HALT_INSTR, 9'h1FF, encoding that stops fetch
WRAP_EN, 1, 1 = PC wraps max->0; 0 = sequential advance past max address faults
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset; also drives instruction memory reset
start  in  1  begin fetching at start_pc (honoured in IDLE/HALTED only)
start_pc  in  ADDR_W  first fetch address
imem_addr  out  ADDR_W  address to instruction memory (combinational mux)
imem_instr  in  INSTR_W  memory data, registered, 1-cycle latency
instr_out  out  INSTR_W  instruction to decode (= imem_instr pass-through)
instr_pc  out  ADDR_W  address of instr_out
instr_valid  out  1  instr_out is a valid fetched instruction
stall  in  1  decode not ready; hold current instruction
redirect_valid  in  1  next fetch comes from redirect_pc
redirect_pc  in  ADDR_W  redirect target
halted  out  1  in HALTED state
fault  out  1  sticky: sequential fetch past max address with WRAP_EN=0
retired  out  CNT_W  saturating count of consumed instructions

Behaviour:
- Reset (async): state IDLE, pc_q=0, instr_pc=0, instr_valid=0, halted=0, fault=0, retired=0. imem_addr=0 while reset is asserted.
- Memory timing: the address on imem_addr at edge N appears on imem_instr after edge N. instr_pc is the registered address of the prior cycle.
- "Consume": instr_valid & !stall, or instr_valid & redirect_valid.
- States IDLE, RUN, HALTED. The encoding is 2 bits.
- IDLE/HALTED:
  - imem_addr=pc_q. instr_valid=0.
  - On start: imem_addr=start_pc, instr_pc<=start_pc, pc_q<=start_pc+1, instr_valid<=1, fault<=0, state<=RUN. First instruction is valid on the next cycle.
- RUN, imem_addr priority:
  1. redirect_valid: imem_addr=redirect_pc; instr_pc<=redirect_pc; pc_q<=redirect_pc+1; instr_valid<=1. stall is ignored and the current instruction is consumed. No bubble.
  2. stall & instr_valid: imem_addr=instr_pc (re-read the same word so instr_out holds). pc_q and instr_pc hold.
  3. else: imem_addr=pc_q; instr_pc<=pc_q; pc_q<=pc_q+1 (mod 2**ADDR_W).
- HALT: when a consume happens with instr_out==HALT_INSTR and redirect_valid=0, state<=HALTED and instr_valid<=0 next cycle.
  - The HALT word itself is presented valid once and counted in retired.
  - HALT under stall takes effect only when stall drops.
- Fault (WRAP_EN=0): consuming a non-HALT instruction at instr_pc=2**ADDR_W-1 without redirect sets fault<=1, state<=HALTED, instr_valid<=0. The wrapped read of address 0 is discarded.
- WRAP_EN=1: PC wraps silently.
- retired increments by 1 per consume and saturates at all-ones.
- start while RUN is ignored.
- Reset mid-run: everything returns to reset values immediately. The memory output also clears to 0 via the shared reset.
- halted is the registered decode of state==HALTED.

Decomposition:
- Shared package tinychip_pkg holds:
  - ADDR_W / INSTR_W defaults
  - HALT_INSTR constant
  - fetch_state_t enum {IDLE, RUN, HALTED}
- No sub-module is needed. The retired saturating counter may be a small sat_counter instance if one already exists in the shared library.

Test Plan:
- Memory {0:9'h18F, 1:9'h19D, 2:9'h1A8, 3:9'h1FF}; start=1, start_pc=0 -> instr_valid from the next cycle with instr_pc 0,1,2,3 and instr_out 18F,19D,1A8,1FF on consecutive cycles; halted=1 and instr_valid=0 after 1FF; retired=4.
- Stall held 3 cycles while instr_pc=1 -> instr_out stays 9'h19D with valid=1 for all 3 cycles, imem_addr=1; after release the next instruction is pc 2 with no skip or duplicate; retired counts pc1 once.
- Redirect_valid with redirect_pc=8 while presenting pc 2 -> next cycle instr_pc=8 with mem[8] valid, then 9, 10; no bubble cycle; redirect asserted together with stall still advances.
- WRAP_EN=0, start_pc=254, non-HALT words at 254 and 255 -> both presented, then fault=1, halted=1, valid=0; start again with start_pc=0 clears fault.
- WRAP_EN=1, same stimulus -> instr_pc sequence 254, 255, 0, 1, and fault stays 0.
- Assert reset for 1 cycle mid-run at pc 5 -> instr_valid=0, retired=0, state IDLE; start with start_pc=5 resumes correctly.
